rom_arbiter: RTL and testbench
==============================

// Module: rom_arbiter
// PURPOSE
//  Two-master arbiter/sequencer for the shared on-chip boot ROM (rom_top).
//  Master 0 is the instruction-fetch port, master 1 the data/loader port.
//  Picks one request round-robin, drives the ROM cs_n/as_n/addr handshake,
//  waits for rom_rdy_n and returns the read word to the winning master.
//  Includes a timeout so a missing rom_rdy_n cannot hang either master.
// PARAMETERS
//  ADDR_W   11  ROM word-address width (matches ROM_ADDR_BUS)
//  DATA_W   32  data word width (matches WORD_DATA_BUS)
//  TMO_CYC  15  max cycles in WAIT before timeout; 4-bit counter, 1..15
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  reset        in   1       synchronous, active-high reset
//  m0_req_n     in   1       master 0 read request, active low, held until m0_rdy_n
//  m0_addr      in   ADDR_W  master 0 word address, stable while m0_req_n low
//  m0_grnt_n    out  1       master 0 owns the ROM, active low
//  m0_rd_data   out  DATA_W  read data to master 0, valid when m0_rdy_n low
//  m0_rdy_n     out  1       master 0 access complete, 1-cycle low pulse
//  m1_req_n     in   1       master 1 read request (as m0)
//  m1_addr      in   ADDR_W  master 1 word address
//  m1_grnt_n    out  1       master 1 grant
//  m1_rd_data   out  DATA_W  read data to master 1
//  m1_rdy_n     out  1       master 1 complete pulse
//  rom_cs_n     out  1       ROM chip select, active low
//  rom_as_n     out  1       ROM address strobe, active low
//  rom_addr     out  ADDR_W  ROM address
//  rom_rd_data  in   DATA_W  ROM read data, valid when rom_rdy_n low
//  rom_rdy_n    in   1       ROM ready, active low
//  tmo_err      out  1       1-cycle high pulse when an access times out
// BEHAVIOUR
//  - Reset: state IDLE; all *_n outputs 1; m*_rd_data, rom_addr 0; tmo_err 0;
//    round-robin pointer prefers m0. Reset mid-access aborts it, no rdy pulse.
//  - All outputs registered. FSM IDLE -> ACCESS -> WAIT -> IDLE.
//  - IDLE: sample m*_req_n. Only one low: grant it. Both low: grant the
//    master NOT served last (m0 after reset). Winner's addr latched into
//    rom_addr, its grnt_n -> 0, rom_cs_n/rom_as_n -> 0; go ACCESS.
//  - ACCESS (exactly 1 cycle): cs_n=0, as_n=0 presented to ROM; next cycle
//    rom_as_n -> 1, rom_cs_n stays 0; go WAIT, timeout counter cleared.
//  - WAIT: on rom_rdy_n==0 register rom_rd_data into winner's rd_data, pulse
//    winner's rdy_n low 1 cycle, release grant, cs_n -> 1, update pointer,
//    go IDLE. Loser's rd_data/rdy_n untouched.
//  - Timeout: counter increments each WAIT cycle; reaching TMO_CYC without
//    rom_rdy_n -> winner rdy_n pulse with rd_data = 0, tmo_err pulse, go IDLE.
//  - Latency with 1-cycle ROM: req low at edge N -> ACCESS N+1, rom_rdy_n N+2,
//    m*_rdy_n low N+3. One IDLE cycle between accesses: 4 cycles/access.
//  - Requester dropping req_n mid-access: access still completes, rdy pulse
//    still issued (ignored). New req seen only in IDLE.
//  - rom_rdy_n low outside WAIT is ignored. Only one grnt_n low at any time.
// TESTING
//  - Reset held 3 cycles with both reqs low -> all *_n=1, rd_data=0, no ROM strobe.
//  - m0 alone, addr=0x005 -> rom_as_n low 1 cycle with rom_addr=0x005,
//    m0_rdy_n low 3 cycles after req, m0_rd_data = ROM word 5.
//  - m0 and m1 both low continuously, addrs 1/2 -> grants alternate m0,m1,m0,
//    each rdy 4 cycles apart, data words 1/2 correct, no overlapping grants.
//  - ROM model holds rom_rdy_n high -> after TMO_CYC=15 WAIT cycles
//    m*_rdy_n pulse, rd_data=0, tmo_err=1 for one cycle, FSM back in IDLE.
//  - reset asserted during WAIT -> next cycle all outputs at reset values,
//    no rdy pulse; subsequent m1 request served normally.
//  - Spurious rom_rdy_n pulse while IDLE -> no rdy/grant activity.

Source files
------------

// File: rtl/rom_arbiter.sv
// Two-master arbiter/sequencer for the shared boot ROM.
// Master 0 is the instruction-fetch port, master 1 the data/loader port.
// One access at a time: IDLE -> ACCESS -> WAIT -> IDLE. All outputs registered.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | arbitrate requests; skipped while a rdy pulse is being issued
//   ACCESS | cs_n/as_n low presented to the ROM for exactly one cycle
//   WAIT   | cs_n held low, waiting for rom_rdy_n or the timeout
module rom_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 15
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              m0_req_n_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  output logic              m0_grnt_n_o,
  output logic [DATA_W-1:0] m0_rd_data_o,
  output logic              m0_rdy_n_o,
  input  logic              m1_req_n_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  output logic              m1_grnt_n_o,
  output logic [DATA_W-1:0] m1_rd_data_o,
  output logic              m1_rdy_n_o,
  output logic              rom_cs_n_o,
  output logic              rom_as_n_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_rd_data_i,
  input  logic              rom_rdy_n_i,
  output logic              tmo_err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // Timeout is a down-counter loaded on entry to WAIT; terminal count is 1.
  localparam logic [3:0] TMO_LOAD = 4'(TMO_CYC);

  state_t            state_q;
  logic              owner_q;     // master that currently owns the ROM
  logic              prio_q;      // master preferred on a tie (0 = m0)
  logic [3:0]        tmo_q;
  logic              m0_grnt_n_q, m1_grnt_n_q;
  logic              m0_rdy_n_q, m1_rdy_n_q;
  logic [DATA_W-1:0] m0_rd_data_q, m1_rd_data_q;
  logic              rom_cs_n_q, rom_as_n_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              tmo_err_q;

  logic              pulse_busy;
  logic              pick_m0, pick_m1;
  logic              wait_done;

  // Arbitration decode. The served master still holds its request during its
  // rdy pulse, so requests are not looked at in that cycle; this also yields
  // the one IDLE cycle between back-to-back accesses.
  always_comb begin
    pulse_busy = !m0_rdy_n_q || !m1_rdy_n_q;
    pick_m0    = !m0_req_n_i && (m1_req_n_i || !prio_q);
    pick_m1    = !m1_req_n_i && !pick_m0;
    wait_done  = !rom_rdy_n_i || (tmo_q == 4'd1);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      prio_q       <= 1'b0;
      tmo_q        <= '0;
      m0_grnt_n_q  <= 1'b1;
      m1_grnt_n_q  <= 1'b1;
      m0_rdy_n_q   <= 1'b1;
      m1_rdy_n_q   <= 1'b1;
      m0_rd_data_q <= '0;
      m1_rd_data_q <= '0;
      rom_cs_n_q   <= 1'b1;
      rom_as_n_q   <= 1'b1;
      rom_addr_q   <= '0;
      tmo_err_q    <= 1'b0;
    end else begin
      m0_rdy_n_q <= 1'b1;
      m1_rdy_n_q <= 1'b1;
      tmo_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!pulse_busy && (pick_m0 || pick_m1)) begin
            owner_q     <= pick_m1;
            rom_addr_q  <= pick_m1 ? m1_addr_i : m0_addr_i;
            m0_grnt_n_q <= !pick_m0;
            m1_grnt_n_q <= !pick_m1;
            rom_cs_n_q  <= 1'b0;
            rom_as_n_q  <= 1'b0;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          rom_as_n_q <= 1'b1;
          tmo_q      <= TMO_LOAD;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (wait_done) begin
            // rom_rdy_n still high here means the timeout fired: return zero.
            if (owner_q) begin
              m1_rdy_n_q   <= 1'b0;
              m1_rd_data_q <= rom_rdy_n_i ? '0 : rom_rd_data_i;
            end else begin
              m0_rdy_n_q   <= 1'b0;
              m0_rd_data_q <= rom_rdy_n_i ? '0 : rom_rd_data_i;
            end
            tmo_err_q   <= rom_rdy_n_i;
            m0_grnt_n_q <= 1'b1;
            m1_grnt_n_q <= 1'b1;
            rom_cs_n_q  <= 1'b1;
            prio_q      <= !owner_q;
            state_q     <= IDLE;
          end else begin
            tmo_q <= tmo_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_grnt_n_o  = m0_grnt_n_q;
  assign m1_grnt_n_o  = m1_grnt_n_q;
  assign m0_rdy_n_o   = m0_rdy_n_q;
  assign m1_rdy_n_o   = m1_rdy_n_q;
  assign m0_rd_data_o = m0_rd_data_q;
  assign m1_rd_data_o = m1_rd_data_q;
  assign rom_cs_n_o   = rom_cs_n_q;
  assign rom_as_n_o   = rom_as_n_q;
  assign rom_addr_o   = rom_addr_q;
  assign tmo_err_o    = tmo_err_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a registered one-cycle ROM model.
module tb_rom_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req_n, m1_req_n;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_grnt_n, m1_grnt_n, m0_rdy_n, m1_rdy_n;
  logic [DW-1:0] m0_rd_data, m1_rd_data;
  logic          rom_cs_n, rom_as_n;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rd_data = '0;
  logic          rom_rdy_n = 1'b1;
  logic          tmo_err;

  logic rom_en = 1'b1;
  logic spur   = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int overlap  = 0;

  always #5 clk = ~clk;

  rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(15)) dut (
    .clk_i(clk), .reset_i(reset),
    .m0_req_n_i(m0_req_n), .m0_addr_i(m0_addr), .m0_grnt_n_o(m0_grnt_n),
    .m0_rd_data_o(m0_rd_data), .m0_rdy_n_o(m0_rdy_n),
    .m1_req_n_i(m1_req_n), .m1_addr_i(m1_addr), .m1_grnt_n_o(m1_grnt_n),
    .m1_rd_data_o(m1_rd_data), .m1_rdy_n_o(m1_rdy_n),
    .rom_cs_n_o(rom_cs_n), .rom_as_n_o(rom_as_n), .rom_addr_o(rom_addr),
    .rom_rd_data_i(rom_rd_data), .rom_rdy_n_i(rom_rdy_n), .tmo_err_o(tmo_err)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return 32'hB007_0000 + 32'(a) * 32'h111;
  endfunction

  // ROM model: answers one cycle after seeing cs_n/as_n low; spur forces a stray pulse.
  always @(posedge clk) begin
    rom_rdy_n   <= ~((rom_en && !rom_cs_n && !rom_as_n) || spur);
    rom_rd_data <= rom_word(rom_addr);
  end

  always @(negedge clk) if (!m0_grnt_n && !m1_grnt_n) overlap++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_g0"}, 64'(m0_grnt_n), 64'd1);
    chk({tag, "_g1"}, 64'(m1_grnt_n), 64'd1);
    chk({tag, "_r0"}, 64'(m0_rdy_n), 64'd1);
    chk({tag, "_r1"}, 64'(m1_rdy_n), 64'd1);
    chk({tag, "_cs"}, 64'(rom_cs_n), 64'd1);
    chk({tag, "_as"}, 64'(rom_as_n), 64'd1);
    chk({tag, "_addr"}, 64'(rom_addr), 64'd0);
    chk({tag, "_d0"}, 64'(m0_rd_data), 64'd0);
    chk({tag, "_d1"}, 64'(m1_rd_data), 64'd0);
    chk({tag, "_tmo"}, 64'(tmo_err), 64'd0);
  endtask

  // Counts negedges after the call until the master's rdy_n is low; -1 on expiry.
  task automatic wait_rdy(input int which, input int limit, output int cyc,
                          output logic [DW-1:0] data, output logic terr);
    cyc = 0; data = '0; terr = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      cyc++;
      if ((which == 0) ? !m0_rdy_n : !m1_rdy_n) begin
        data = (which == 0) ? m0_rd_data : m1_rd_data;
        terr = tmo_err;
        return;
      end
    end
    cyc = -1;
  endtask

  int            cyc;
  logic [DW-1:0] dat;
  logic          terr;
  int            ev_who[3];
  logic [DW-1:0] ev_dat[3];
  int            ev_cyc[3];
  int            ne;
  int            stray;

  initial begin
    reset = 1'b1; m0_req_n = 1'b0; m1_req_n = 1'b0; m0_addr = '0; m1_addr = '0;

    // Reset held 3 cycles with both requests low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_strobe", 64'(rom_as_n), 64'd1);
    end
    chk_reset_vals("rst");
    m0_req_n = 1'b1; m1_req_n = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // m0 alone, address 5, stepped cycle by cycle.
    m0_addr = 11'h005; m0_req_n = 1'b0;
    @(negedge clk);
    chk("m0_grnt", 64'(m0_grnt_n), 64'd0);
    chk("m0_g1_idle", 64'(m1_grnt_n), 64'd1);
    chk("m0_as_low", 64'(rom_as_n), 64'd0);
    chk("m0_cs_low", 64'(rom_cs_n), 64'd0);
    chk("m0_addr", 64'(rom_addr), 64'h005);
    @(negedge clk);
    chk("m0_as_one_cyc", 64'(rom_as_n), 64'd1);
    chk("m0_cs_wait", 64'(rom_cs_n), 64'd0);
    chk("m0_rdy_early", 64'(m0_rdy_n), 64'd1);
    @(negedge clk);
    chk("m0_rdy", 64'(m0_rdy_n), 64'd0);
    chk("m0_data", 64'(m0_rd_data), 64'(rom_word(11'h005)));
    chk("m0_rel", 64'(m0_grnt_n), 64'd1);
    chk("m0_cs_rel", 64'(rom_cs_n), 64'd1);
    chk("m0_m1_quiet", 64'(m1_rdy_n), 64'd1);
    m0_req_n = 1'b1;
    @(negedge clk);
    chk("m0_rdy_pulse", 64'(m0_rdy_n), 64'd1);
    chk("m0_no_regrant", 64'(m0_grnt_n), 64'd1);

    // Fresh reset so the pointer prefers m0, then both request continuously.
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    ev_who = '{-1, -1, -1}; ev_dat = '{0, 0, 0}; ev_cyc = '{-1, -1, -1}; ne = 0;
    m0_addr = 11'h001; m1_addr = 11'h002; m0_req_n = 1'b0; m1_req_n = 1'b0;
    for (int i = 0; i < 30 && ne < 3; i++) begin
      @(negedge clk);
      if (!m0_rdy_n) begin
        ev_who[ne] = 0; ev_dat[ne] = m0_rd_data; ev_cyc[ne] = i; ne++;
      end else if (!m1_rdy_n) begin
        ev_who[ne] = 1; ev_dat[ne] = m1_rd_data; ev_cyc[ne] = i; ne++;
      end
    end
    m0_req_n = 1'b1; m1_req_n = 1'b1;
    chk("rr_count", 64'(ne), 64'd3);
    chk("rr_who0", 64'(ev_who[0]), 64'd0);
    chk("rr_who1", 64'(ev_who[1]), 64'd1);
    chk("rr_who2", 64'(ev_who[2]), 64'd0);
    chk("rr_dat0", 64'(ev_dat[0]), 64'(rom_word(11'h001)));
    chk("rr_dat1", 64'(ev_dat[1]), 64'(rom_word(11'h002)));
    chk("rr_dat2", 64'(ev_dat[2]), 64'(rom_word(11'h001)));
    chk("rr_first_lat", 64'(ev_cyc[0]), 64'd2);
    chk("rr_gap01", 64'(ev_cyc[1] - ev_cyc[0]), 64'd4);
    chk("rr_gap12", 64'(ev_cyc[2] - ev_cyc[1]), 64'd4);
    repeat (6) @(negedge clk);
    chk("rr_drained", 64'({m0_grnt_n, m1_grnt_n, rom_cs_n}), 64'b111);

    // Timeout: ROM never answers an m1 access.
    rom_en = 1'b0;
    m1_addr = 11'h007; m1_req_n = 1'b0;
    wait_rdy(1, 40, cyc, dat, terr);
    m1_req_n = 1'b1;
    chk("tmo_lat", 64'(cyc), 64'd17);
    chk("tmo_data", 64'(dat), 64'd0);
    chk("tmo_err", 64'(terr), 64'd1);
    chk("tmo_m0_untouched", 64'(m0_rd_data), 64'(rom_word(11'h001)));
    @(negedge clk);
    chk("tmo_err_pulse", 64'(tmo_err), 64'd0);
    chk("tmo_idle", 64'({m0_grnt_n, m1_grnt_n, rom_cs_n, m1_rdy_n}), 64'b1111);

    // Reset while in WAIT aborts the access with no rdy pulse.
    m0_addr = 11'h009; m0_req_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rw_in_wait", 64'({m0_grnt_n, rom_cs_n, rom_as_n}), 64'b001);
    reset = 1'b1; m0_req_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("rw");
    reset = 1'b0; rom_en = 1'b1;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (!m0_rdy_n || !m1_rdy_n || tmo_err) stray++;
    end
    chk("rw_no_rdy", 64'(stray), 64'd0);
    m1_addr = 11'h003; m1_req_n = 1'b0;
    wait_rdy(1, 20, cyc, dat, terr);
    m1_req_n = 1'b1;
    chk("rw_m1_lat", 64'(cyc), 64'd3);
    chk("rw_m1_data", 64'(dat), 64'(rom_word(11'h003)));
    chk("rw_m1_tmo", 64'(terr), 64'd0);
    repeat (3) @(negedge clk);

    // Spurious rom_rdy_n while IDLE.
    spur = 1'b1; @(negedge clk); spur = 1'b0;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (!m0_rdy_n || !m1_rdy_n || !m0_grnt_n || !m1_grnt_n || !rom_cs_n || tmo_err) stray++;
    end
    chk("spur_quiet", 64'(stray), 64'd0);
    chk("spur_d1_kept", 64'(m1_rd_data), 64'(rom_word(11'h003)));

    chk("no_overlap", 64'(overlap), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
